// File: rtl/nkb2onehot_decoder.sv
// rtl/nkb2onehot_decoder.sv - registered binary-index to one-hot decoder with 2-entry elastic buffer
module nkb2onehot_decoder #(
   parameter  int LEN       = 4,
   parameter  int ERR_CNT_W = 8,
   localparam int BITS      = (LEN > 1) ? $clog2(LEN) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [BITS-1:0]      i_nkb,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic [LEN-1:0]       o_onehot,
   output logic                 o_err,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [ERR_CNT_W-1:0] o_err_cnt,
   input  logic                 i_err_clr
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   // One extra bit so the range compare is meaningful when LEN is a power of two.
   localparam logic [BITS:0]      LEN_V   = (BITS + 1)'(LEN);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   state_t               state;
   state_t               state_nxt;
   logic                 in_range;
   logic [LEN-1:0]       dec_onehot;
   logic                 accept;
   logic                 emit;
   logic                 err_inc;
   logic [LEN-1:0]       skid_onehot;
   logic                 skid_err;
   logic                 load_out_new;
   logic                 load_out_skid;
   logic                 clr_out;
   logic                 load_skid;

   assign accept  = i_valid & o_ready;
   assign emit    = o_valid & i_ready;
   assign o_valid = (state != EMPTY);
   assign err_inc = accept & ~in_range;

   // Decode the incoming index; out-of-range indices give an all-zero word.
   always_comb begin
      in_range   = ({1'b0, i_nkb} < LEN_V);
      dec_onehot = '0;
      for (int k = 0; k < LEN; k++) begin
         dec_onehot[k] = in_range && (i_nkb == BITS'(k));
      end
   end

   // Occupancy next-state and register load controls.
   always_comb begin
      state_nxt     = state;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      clr_out       = 1'b0;
      load_skid     = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt    = ONE;
               load_out_new = 1'b1;
            end
         end
         ONE: begin
            if (accept && emit) begin
               load_out_new = 1'b1;
            end else if (accept) begin
               state_nxt = FULL;
               load_skid = 1'b1;
            end else if (emit) begin
               state_nxt = EMPTY;
               clr_out   = 1'b1;
            end
         end
         FULL: begin
            if (emit) begin
               state_nxt     = ONE;
               load_out_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // State register; ready is registered from the next state so it drops on entry to FULL.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= EMPTY;
         o_ready <= 1'b0;
      end else begin
         state   <= state_nxt;
         o_ready <= (state_nxt != FULL);
      end
   end

   // Output register: new beat, beat promoted from skid, or cleared when drained.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_onehot <= '0;
         o_err    <= 1'b0;
      end else if (load_out_new) begin
         o_onehot <= dec_onehot;
         o_err    <= ~in_range;
      end else if (load_out_skid) begin
         o_onehot <= skid_onehot;
         o_err    <= skid_err;
      end else if (clr_out) begin
         o_onehot <= '0;
         o_err    <= 1'b0;
      end
   end

   // Skid register catches the beat accepted while the output is stalled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         skid_onehot <= '0;
         skid_err    <= 1'b0;
      end else if (load_skid) begin
         skid_onehot <= dec_onehot;
         skid_err    <= ~in_range;
      end
   end

   // Saturating count of accepted out-of-range beats; clear wins but keeps a coincident error.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_err_cnt <= '0;
      end else if (i_err_clr) begin
         o_err_cnt <= ERR_CNT_W'(err_inc);
      end else if (err_inc && (o_err_cnt != CNT_MAX)) begin
         o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_nkb2onehot_decoder.sv
// tb/tb_nkb2onehot_decoder.sv - self-checking bench for nkb2onehot_decoder
module tb_nkb2onehot_decoder;

   localparam int LEN       = 5;
   localparam int ERR_CNT_W = 3;
   localparam int BITS      = 3;
   localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

   logic                 i_clk = 1'b0;
   logic                 i_rst = 1'b1;
   logic [BITS-1:0]      i_nkb = '0;
   logic                 i_valid = 1'b0;
   logic                 o_ready;
   logic [LEN-1:0]       o_onehot;
   logic                 o_err;
   logic                 o_valid;
   logic                 i_ready = 1'b0;
   logic [ERR_CNT_W-1:0] o_err_cnt;
   logic                 i_err_clr = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   nkb2onehot_decoder #(.LEN(LEN), .ERR_CNT_W(ERR_CNT_W)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_nkb     (i_nkb),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_onehot  (o_onehot),
      .o_err     (o_err),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_err_cnt (o_err_cnt),
      .i_err_clr (i_err_clr)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a FIFO of capacity two holding decoded beats.
   typedef struct {
      logic [LEN-1:0] oh;
      logic           err;
   } beat_t;

   beat_t q[$];
   beat_t nb;
   bit    mdl_rdy = 1'b0;
   int    mdl_cnt = 0;
   int    mdl_acc = 0;
   bit    m_acc;
   bit    m_emi;
   bit    m_bad;

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         q.delete();
         mdl_rdy = 1'b0;
         mdl_cnt = 0;
      end else begin
         m_acc = i_valid && mdl_rdy;
         m_emi = (q.size() > 0) && i_ready;
         m_bad = m_acc && (int'(i_nkb) >= LEN);
         if (m_emi) void'(q.pop_front());
         if (m_acc) begin
            nb.err = (int'(i_nkb) >= LEN);
            nb.oh  = nb.err ? '0 : LEN'(1 << int'(i_nkb));
            q.push_back(nb);
            mdl_acc++;
         end
         if (i_err_clr) mdl_cnt = m_bad ? 1 : 0;
         else if (m_bad && mdl_cnt < CNT_MAX) mdl_cnt++;
         mdl_rdy = (q.size() < 2);
      end
   end

   always @(posedge i_clk) begin
      if (!i_rst && i_valid)
         assert (!$isunknown(i_nkb)) else $display("FAIL nkb_x: i_nkb unknown while valid");
   end

   // Compare DUT against the model every cycle, plus the hold-while-stalled rule.
   bit             hold = 1'b0;
   logic [LEN-1:0] prev_oh;
   logic           prev_err;

   always @(negedge i_clk) begin
      chk("valid", o_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("onehot", o_onehot, q[0].oh);
         chk("err", o_err, q[0].err);
      end else begin
         chk("onehot_idle", o_onehot, 0);
         chk("err_idle", o_err, 0);
      end
      chk("ready", o_ready, mdl_rdy);
      chk("err_cnt", o_err_cnt, mdl_cnt);
      if (hold && !i_rst) begin
         chk("stable_onehot", o_onehot, prev_oh);
         chk("stable_err", o_err, prev_err);
      end
      hold     = !i_rst && o_valid && !i_ready;
      prev_oh  = o_onehot;
      prev_err = o_err;
   end

   task automatic step(input logic v, input int n, input logic r, input logic c);
      @(posedge i_clk);
      #1;
      i_valid   = v;
      i_nkb     = BITS'(n);
      i_ready   = r;
      i_err_clr = c;
   endtask

   logic [LEN-1:0]       t1_exp[4]  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
   logic [ERR_CNT_W-1:0] t4_exp[9]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};

   initial begin
      int cyc;
      int start;

      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 0);
      chk("rst_cnt", o_err_cnt, 0);
      i_rst = 1'b0;

      // T1: back-to-back in-range stream
      step(1, 0, 1, 0);
      chk("t1_ready_up", o_ready, 1);
      for (int k = 1; k <= 4; k++) begin
         step(k < 4, k, 1, 0);
         chk("t1_onehot", o_onehot, t1_exp[k-1]);
         chk("t1_err", o_err, 0);
         chk("t1_ready", o_ready, 1);
      end
      step(0, 0, 1, 0);
      chk("t1_drained", o_valid, 0);

      // T2: out-of-range indices
      step(1, 5, 1, 0);
      step(1, 7, 1, 0);
      chk("t2_oh0", o_onehot, 5'b00000);
      chk("t2_err0", o_err, 1);
      step(1, 4, 1, 0);
      chk("t2_oh1", o_onehot, 5'b00000);
      chk("t2_err1", o_err, 1);
      step(0, 0, 1, 0);
      chk("t2_oh2", o_onehot, 5'b10000);
      chk("t2_err2", o_err, 0);
      chk("t2_cnt", o_err_cnt, 2);

      // T3: backpressure fills both entries
      step(1, 2, 0, 0);
      step(1, 3, 0, 0);
      chk("t3_oh_first", o_onehot, 5'b00100);
      chk("t3_ready_one", o_ready, 1);
      step(0, 0, 0, 0);
      chk("t3_ready_full", o_ready, 0);
      chk("t3_hold", o_onehot, 5'b00100);
      step(0, 0, 1, 0);
      chk("t3_hold2", o_onehot, 5'b00100);
      step(0, 0, 1, 0);
      chk("t3_second", o_onehot, 5'b01000);
      chk("t3_ready_back", o_ready, 1);
      step(0, 0, 1, 0);
      chk("t3_empty", o_valid, 0);

      // T4: saturation and clear
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
      chk("t4_clr", o_err_cnt, 0);
      for (int k = 0; k < 9; k++) begin
         step(1, 5 + (k % 3), 1, 0);
         chk("t4_cnt", o_err_cnt, t4_exp[k]);
      end
      step(0, 0, 1, 0);
      chk("t4_sat", o_err_cnt, 7);
      step(1, 6, 1, 1);
      step(0, 0, 1, 0);
      chk("t4_clr_inc", o_err_cnt, 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
      chk("t4_clr_only", o_err_cnt, 0);

      // T5: async reset while FULL
      step(0, 0, 1, 0);
      step(1, 1, 0, 0);
      step(1, 7, 0, 0);
      step(0, 0, 0, 0);
      chk("t5_full", o_ready, 0);
      chk("t5_cnt", o_err_cnt, 1);
      #2 i_rst = 1'b1;
      #1;
      chk("t5_valid", o_valid, 0);
      chk("t5_ready", o_ready, 0);
      chk("t5_onehot", o_onehot, 0);
      chk("t5_err", o_err, 0);
      chk("t5_cnt0", o_err_cnt, 0);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      chk("t5_ready_rel", o_ready, 0);
      step(0, 0, 1, 0);
      chk("t5_ready_up", o_ready, 1);
      step(1, 3, 1, 0);
      step(0, 0, 1, 0);
      chk("t5_decode", o_onehot, 5'b01000);
      chk("t5_dvalid", o_valid, 1);

      // T6: random traffic against the model
      start = mdl_acc;
      cyc   = 0;
      while ((mdl_acc - start) < 10000 && cyc < 60000) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
         cyc++;
      end
      chk("t6_budget", cyc < 60000, 1);
      repeat (3) step(0, 0, 1, 0);
      chk("t6_drained", o_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
